key_conditioner: RTL and testbench
==================================

Name: key_conditioner

Overview:
Front-end input stage that feeds the game core. Takes the six raw board push-buttons and produces the single-cycle `pressed_left/right/up/down/speed_up_down/pause_or_start` event pulses the game core consumes. Each key passes through three steps:
- 2-flop synchroniser
- counter-based debouncer
- per-key auto-repeat state machine, enabled only for movement keys

Also exports the debounced key levels.

Parameters:
- DEBOUNCE_CYC, 1_000_000, cycles a synchronised level must stay unchanged before it is accepted (20 ms @ 50 MHz); min 2
- REPEAT_DELAY_CYC, 15_000_000, cycles from accepted press to first auto-repeat pulse (300 ms); min 2
- REPEAT_RATE_CYC, 5_000_000, cycles between subsequent auto-repeat pulses (100 ms); min 2
- REPEAT_MASK, 6'b001011, per-key auto-repeat enable; bit order as raw_keys (left, right, down enabled)
- KEY_ACTIVE_LOW, 1, 1 = raw_keys low means pressed; 0 = high means pressed

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- raw_keys  in  6  asynchronous buttons; [0]=left [1]=right [2]=up [3]=down [4]=speed [5]=pause
- pressed_left  out  1  one-cycle event
- pressed_right  out  1  one-cycle event
- pressed_up  out  1  one-cycle event
- pressed_down  out  1  one-cycle event
- pressed_speed_up_down  out  1  one-cycle event
- pressed_pause_or_start  out  1  one-cycle event
- key_state  out  6  debounced level per key, 1 = held

Behaviour:
- Reset: rstn is asynchronous, active-low; clock is clk.
  - All outputs go to 0.
  - Synchroniser flops reset to the released level; stable levels reset to 0.
  - All counters reset to 0; all FSMs go to IDLE.
  - Reset asserted mid-operation aborts any debounce or repeat immediately; no pulse is emitted on the reset-release cycle.
- Polarity: internal level k = raw_keys ^ {6{KEY_ACTIVE_LOW}} (1 = pressed).
- Synchroniser: two flops per key; s2 is the only signal used downstream.
- Debounce, per key:
  - If s2 == stable, the counter is cleared.
  - Otherwise the counter increments.
  - When the counter == DEBOUNCE_CYC-1 and s2 != stable: stable <= s2 and the counter clears.
  - Any bounce (s2 returning to stable) restarts the count.
- Press latency: a raw press held clean produces the press pulse exactly DEBOUNCE_CYC+2 cycles after the first clk edge that samples it. The stable rise and the pulse occur in the same registered cycle. Release has the same latency for key_state, with no pulse.
- Pulse rule: the press event is registered; high exactly one cycle per accepted 0->1 transition; never emitted on release.
- Repeat FSM, per key with its REPEAT_MASK bit = 1; states IDLE, DELAY, REPEAT; repeat counter shared within the channel:
  - IDLE: on accepted press, emit press pulse -> DELAY, counter = 0.
  - DELAY: counter increments. At REPEAT_DELAY_CYC-1: pulse -> REPEAT, counter = 0. First repeat pulse comes REPEAT_DELAY_CYC cycles after the press pulse.
  - REPEAT: at REPEAT_RATE_CYC-1: pulse, counter = 0, stay in REPEAT.
  - Any state: stable == 0 -> IDLE and counter = 0 the same cycle; a repeat pulse due in that cycle is suppressed.
  - Keys with mask bit = 0 stay in IDLE: exactly one pulse per press regardless of hold time (required: pause/speed are toggles downstream).
- Independence: all six channels are independent. Simultaneous presses produce simultaneous pulses; no priority or arbitration.
- Key held across reset release: treated as a new press; one pulse after DEBOUNCE_CYC+2 cycles.
- Counter widths: $clog2 of the respective parameter. Counters saturate only at their terminal value; no wrap-around is reachable.

Decomposition:
- Package tetris_key_pkg:
  - KEY_NUM = 6
  - index constants KEY_LEFT=0, KEY_RIGHT=1, KEY_UP=2, KEY_DOWN=3, KEY_SPEED=4, KEY_PAUSE=5
  - repeat FSM state enum {IDLE, DELAY, REPEAT}
- Sub-module key_channel (synchroniser + debounce + repeat FSM; parameters DEBOUNCE_CYC, REPEAT_DELAY_CYC, REPEAT_RATE_CYC, REPEAT_EN). Instantiated KEY_NUM times by a generate loop. The top maps the pulse vector to the named outputs.

Test Plan:
All tests use DEBOUNCE_CYC=4, REPEAT_DELAY_CYC=10, REPEAT_RATE_CYC=3, KEY_ACTIVE_LOW=0.
- Clean press: raw_keys[2] 0->1 held 30 cycles -> pressed_up high for exactly 1 cycle, 6 cycles after the first sampling edge; no further pulses. key_state[2]=1 in the same cycle; key_state[2] returns to 0 6 cycles after release.
- Bounce: raw_keys[0] toggles every 2 cycles for 20 cycles, then held 1 -> no pulse during the bounce; a single pressed_left 6 cycles after the final rise.
- Auto-repeat: raw_keys[3] held 40 cycles -> pressed_down at t0, t0+10, t0+13, t0+16, …; release -> no pulse after key_state[3] falls.
- Non-repeat key: raw_keys[5] held 100 cycles -> exactly one pressed_pause_or_start. Second press after release -> one more pulse.
- Simultaneous: raw_keys[0] and raw_keys[1] rise in the same cycle -> pressed_left and pressed_right pulse in the same cycle; repeat pulses stay aligned.
- Reset mid-repeat: raw_keys[1] held, rstn low for 3 cycles during REPEAT -> all outputs 0 immediately. After release with the key still held: one pressed_right 6 cycles later, then the first repeat 10 cycles after that.

Source files
------------

// File: rtl/tetris_key_pkg.sv
// Shared definitions for the key conditioning front end: key count,
// per-key bit positions in raw_keys, and the auto-repeat state encoding.
package tetris_key_pkg;

    localparam int KEY_NUM   = 6;

    localparam int KEY_LEFT  = 0;
    localparam int KEY_RIGHT = 1;
    localparam int KEY_UP    = 2;
    localparam int KEY_DOWN  = 3;
    localparam int KEY_SPEED = 4;
    localparam int KEY_PAUSE = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rep_state_t;

endpackage

// File: rtl/key_conditioner_if.sv
// Bundle of the board-facing raw buttons and the game-facing key events.
// The conditioner uses the slave view; whatever drives the buttons uses master.
interface key_conditioner_if;
    import tetris_key_pkg::*;

    logic [KEY_NUM-1:0] raw_keys;
    logic               pressed_left;
    logic               pressed_right;
    logic               pressed_up;
    logic               pressed_down;
    logic               pressed_speed_up_down;
    logic               pressed_pause_or_start;
    logic [KEY_NUM-1:0] key_state;

    modport master (
        output raw_keys,
        input  pressed_left,
        input  pressed_right,
        input  pressed_up,
        input  pressed_down,
        input  pressed_speed_up_down,
        input  pressed_pause_or_start,
        input  key_state
    );

    modport slave (
        input  raw_keys,
        output pressed_left,
        output pressed_right,
        output pressed_up,
        output pressed_down,
        output pressed_speed_up_down,
        output pressed_pause_or_start,
        output key_state
    );

endinterface

// File: rtl/key_channel.sv
// One key: 2-flop synchroniser, counter debouncer and an optional
// auto-repeat FSM. The press pulse is registered on the same edge at which
// the debounced level rises, so the pulse and key_state go high together.
module key_channel
    import tetris_key_pkg::*;
#(
    parameter int DEBOUNCE_CYC     = 1_000_000,
    parameter int REPEAT_DELAY_CYC = 15_000_000,
    parameter int REPEAT_RATE_CYC  = 5_000_000,
    parameter bit REPEAT_EN        = 1'b1
) (
    input  logic clk,
    input  logic rstn,
    input  logic key,      // 1 = pressed, already polarity corrected
    output logic pulse,    // one-cycle press / repeat event
    output logic state     // debounced level
);

    localparam int DW   = $clog2(DEBOUNCE_CYC);
    localparam int RMAX = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ? REPEAT_DELAY_CYC
                                                              : REPEAT_RATE_CYC;
    localparam int RW   = $clog2(RMAX);

    logic          s1;
    logic          s2;
    logic          stable;
    logic [DW-1:0] db_cnt;
    logic          accept_rise;

    rep_state_t    rep_state;
    rep_state_t    rep_state_nxt;
    logic [RW-1:0] rep_cnt;
    logic [RW-1:0] rep_cnt_nxt;
    logic          pulse_nxt;

    // Bring the asynchronous button into the clk domain; released level on reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= key;
            s2 <= s1;
        end
    end

    // Accept a new level only after it has differed from stable for DEBOUNCE_CYC edges.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stable <= 1'b0;
            db_cnt <= '0;
        end else if (s2 == stable) begin
            db_cnt <= '0;
        end else if (db_cnt == DW'(DEBOUNCE_CYC - 1)) begin
            stable <= s2;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    // The debouncer is about to accept a 0->1 transition on this edge.
    assign accept_rise = s2 & ~stable & (db_cnt == DW'(DEBOUNCE_CYC - 1));

    // Repeat FSM state, shared repeat counter and registered event output.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rep_state <= IDLE;
            rep_cnt   <= '0;
            pulse     <= 1'b0;
        end else begin
            rep_state <= rep_state_nxt;
            rep_cnt   <= rep_cnt_nxt;
            pulse     <= pulse_nxt;
        end
    end

    // Next-state and pulse decision; a released key returns to IDLE without pulsing.
    always_comb begin
        rep_state_nxt = rep_state;
        rep_cnt_nxt   = rep_cnt;
        pulse_nxt     = 1'b0;
        case (rep_state)
            IDLE: begin
                rep_cnt_nxt = '0;
                if (accept_rise) begin
                    pulse_nxt = 1'b1;
                    if (REPEAT_EN) begin
                        rep_state_nxt = DELAY;
                    end
                end
            end
            DELAY: begin
                if (!stable) begin
                    rep_state_nxt = IDLE;
                    rep_cnt_nxt   = '0;
                end else if (rep_cnt == RW'(REPEAT_DELAY_CYC - 1)) begin
                    pulse_nxt     = 1'b1;
                    rep_state_nxt = REPEAT;
                    rep_cnt_nxt   = '0;
                end else begin
                    rep_cnt_nxt   = rep_cnt + 1'b1;
                end
            end
            REPEAT: begin
                if (!stable) begin
                    rep_state_nxt = IDLE;
                    rep_cnt_nxt   = '0;
                end else if (rep_cnt == RW'(REPEAT_RATE_CYC - 1)) begin
                    pulse_nxt     = 1'b1;
                    rep_cnt_nxt   = '0;
                end else begin
                    rep_cnt_nxt   = rep_cnt + 1'b1;
                end
            end
            default: begin
                rep_state_nxt = IDLE;
                rep_cnt_nxt   = '0;
            end
        endcase
    end

    assign state = stable;

endmodule

// File: rtl/key_conditioner.sv
// Front end for the game core: turns the six raw board buttons into
// debounced levels and single-cycle press / auto-repeat events.
module key_conditioner
    import tetris_key_pkg::*;
#(
    parameter int                 DEBOUNCE_CYC     = 1_000_000,
    parameter int                 REPEAT_DELAY_CYC = 15_000_000,
    parameter int                 REPEAT_RATE_CYC  = 5_000_000,
    parameter logic [KEY_NUM-1:0] REPEAT_MASK      = 6'b001011,
    parameter bit                 KEY_ACTIVE_LOW   = 1'b1
) (
    input  logic             clk,
    input  logic             rstn,
    key_conditioner_if.slave keys
);

    logic [KEY_NUM-1:0] level;
    logic [KEY_NUM-1:0] pulse_vec;
    logic [KEY_NUM-1:0] stable_vec;

    // Internal convention everywhere downstream: 1 = pressed.
    assign level = keys.raw_keys ^ {KEY_NUM{KEY_ACTIVE_LOW}};

    for (genvar i = 0; i < KEY_NUM; i++) begin : g_chan
        key_channel #(
            .DEBOUNCE_CYC     (DEBOUNCE_CYC),
            .REPEAT_DELAY_CYC (REPEAT_DELAY_CYC),
            .REPEAT_RATE_CYC  (REPEAT_RATE_CYC),
            .REPEAT_EN        (REPEAT_MASK[i])
        ) u_chan (
            .clk   (clk),
            .rstn  (rstn),
            .key   (level[i]),
            .pulse (pulse_vec[i]),
            .state (stable_vec[i])
        );
    end

    assign keys.pressed_left           = pulse_vec[KEY_LEFT];
    assign keys.pressed_right          = pulse_vec[KEY_RIGHT];
    assign keys.pressed_up             = pulse_vec[KEY_UP];
    assign keys.pressed_down           = pulse_vec[KEY_DOWN];
    assign keys.pressed_speed_up_down  = pulse_vec[KEY_SPEED];
    assign keys.pressed_pause_or_start = pulse_vec[KEY_PAUSE];
    assign keys.key_state              = stable_vec;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with short debounce/repeat timing.
module tb_key_conditioner;
    import tetris_key_pkg::*;

    localparam int DEB = 4;
    localparam int RD  = 10;
    localparam int RR  = 3;
    localparam int LAT = DEB + 2;

    logic clk;
    logic rstn;
    int   n_tests;
    int   n_fail;

    key_conditioner_if kif ();

    key_conditioner #(
        .DEBOUNCE_CYC     (DEB),
        .REPEAT_DELAY_CYC (RD),
        .REPEAT_RATE_CYC  (RR),
        .REPEAT_MASK      (6'b001011),
        .KEY_ACTIVE_LOW   (1'b0)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .keys (kif)
    );

    logic [5:0] pv;
    assign pv = {kif.pressed_pause_or_start, kif.pressed_speed_up_down, kif.pressed_down,
                 kif.pressed_up, kif.pressed_right, kif.pressed_left};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time expired, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Press the given keys, hold them 'hold' cycles, release, then watch 12 more cycles.
    // Pulses: press at LAT, repeats at LAT+RD, then every RR while stable is still 1.
    task automatic press_run(input logic [5:0] bits, input int hold, input bit rep,
                             input string tag);
        logic [5:0] exp_p;
        logic [5:0] exp_s;
        kif.raw_keys = kif.raw_keys | bits;
        for (int c = 1; c <= hold + 12; c++) begin
            tick();
            exp_p = 6'b0;
            if (c == LAT)
                exp_p = bits;
            if (rep && c >= LAT + RD && ((c - LAT - RD) % RR) == 0 && c <= hold + LAT)
                exp_p = bits;
            exp_s = (c >= LAT && c < hold + LAT) ? bits : 6'b0;
            chk({tag, "_pulse"}, 32'(pv), 32'(exp_p));
            chk({tag, "_state"}, 32'(kif.key_state), 32'(exp_s));
            if (c == hold)
                kif.raw_keys = kif.raw_keys & ~bits;
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rstn = 1'b0;
        kif.raw_keys = 6'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_pulse", 32'(pv), 32'h0);
        chk("reset_state", 32'(kif.key_state), 32'h0);
        rstn = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("idle_pulse", 32'(pv), 32'h0);
        end

        // Clean press on a non-repeating key (up)
        press_run(6'b000100, 30, 1'b0, "clean_up");

        // Bounce on left: toggles every 2 cycles for 20 cycles, then a clean hold
        for (int c = 0; c < 20; c++) begin
            kif.raw_keys[0] = (((c / 2) % 2) == 0);
            tick();
            chk("bounce_pulse", 32'(pv), 32'h0);
            chk("bounce_state", 32'(kif.key_state), 32'h0);
        end
        press_run(6'b000001, 8, 1'b1, "bounce_left");

        // Auto-repeat on down
        press_run(6'b001000, 42, 1'b1, "repeat_down");

        // Non-repeating pause: one pulse per press, twice
        press_run(6'b100000, 100, 1'b0, "pause_1");
        press_run(6'b100000, 20, 1'b0, "pause_2");

        // Speed key also never repeats
        press_run(6'b010000, 30, 1'b0, "speed");

        // Simultaneous left + right stay aligned through repeats
        press_run(6'b000011, 26, 1'b1, "simul_lr");

        // Reset in the middle of repeating on right
        kif.raw_keys[1] = 1'b1;
        for (int c = 1; c <= 19; c++) begin
            tick();
            chk("rstpre_pulse", 32'(pv),
                (c == LAT || c == LAT + RD || c == LAT + RD + RR) ? 32'h2 : 32'h0);
        end
        rstn = 1'b0;
        #1;
        chk("rst_async_pulse", 32'(pv), 32'h0);
        chk("rst_async_state", 32'(kif.key_state), 32'h0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rst_hold_pulse", 32'(pv), 32'h0);
            chk("rst_hold_state", 32'(kif.key_state), 32'h0);
        end
        rstn = 1'b1;
        press_run(6'b000010, 20, 1'b1, "rst_right");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
